gcd_stein: RTL
==============

GCD_STEIN -- requirements
Module: gcd_stein

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 2..32.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-high reset.
REQ-004 Port a, input, WIDTH: unsigned operand A, sampled only on an accepted start.
REQ-005 Port b, input, WIDTH: unsigned operand B, sampled only on an accepted start.
REQ-006 Port start, input, 1: request a new computation.
REQ-007 Port res_fetch, input, 1: consumer acknowledges the result.
REQ-008 Port busy, output, 1: high while in CALC.
REQ-009 Port res_rdy, output, 1: high while in DONE; the result is valid.
REQ-010 Port res, output, WIDTH: gcd(a,b).
REQ-011 Port coprime, output, 1: high when res == 1.
REQ-012 Port zero_err, output, 1: high when a == 0 and b == 0.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 In IDLE, start SHALL be accepted: latch x=a, y=b, k=0, then go to CALC, except in the zero-operand case (REQ-015).
REQ-015 Zero-operand case: if a==0 or b==0 at accept, the block SHALL go directly to DONE with res=a|b, zero_err=(a==0 && b==0), and coprime=(res==1).
REQ-016 In CALC, the block SHALL perform exactly one Stein step per cycle, evaluated in this priority order:
- x==y: res=x<<k, go to DONE.
- x and y both even: x>>=1, y>>=1, k+=1.
- x even: x>>=1.
- y even: y>>=1.
- x>y: x=(x-y)>>1.
- else: y=(y-x)>>1.
REQ-017 k SHALL be $clog2(WIDTH)+1 bits wide, and x<<k SHALL never overflow WIDTH bits.
REQ-018 Latency from an accepted start to res_rdy SHALL NOT exceed 2*WIDTH+1 cycles.
REQ-019 start SHALL be ignored in CALC, and a, b SHALL be don't-care there.
REQ-020 In DONE, res, coprime and zero_err SHALL be held stable until res_fetch is sampled high.
REQ-021 In DONE, res_fetch=1 with start=0 SHALL go to IDLE; res_rdy SHALL deassert the next cycle.
REQ-022 In DONE, res_fetch=1 with start=1 SHALL accept the new operands (per REQ-014/015) in the same cycle, with no IDLE cycle between.
REQ-023 In DONE, start=1 with res_fetch=0 SHALL be ignored.
REQ-024 In IDLE, res_fetch SHALL be ignored.
REQ-025 res, coprime and zero_err SHALL keep their last values in IDLE and CALC, and SHALL be updated only on entry to DONE.
REQ-026 busy and res_rdy SHALL be registered outputs and SHALL never be high together.

Reset
REQ-027 While rst=1, the block SHALL asynchronously force: state=IDLE, x=y=k=0, busy=0, res_rdy=0, res=0, coprime=0, zero_err=0.
REQ-028 Reset asserted in CALC or DONE SHALL abort the operation and discard the result; after rst falls, the block SHALL wait in IDLE for a new start.
REQ-029 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification (WIDTH=8 unless stated)
REQ-030 a=60, b=48, 1-cycle start pulse -> busy high, then res_rdy within 17 cycles with res=12, coprime=0; res_fetch pulse -> IDLE; then a=30, b=24 -> res=6.
REQ-031 a=17, b=5 -> res=1, coprime=1; a=255, b=255 -> res=255 one cycle after entering CALC.
REQ-032 a=0, b=0 -> DONE one cycle after start with res=0, zero_err=1, busy never high; a=0, b=9 -> res=9, zero_err=0.
REQ-033 In DONE with res=12: assert res_fetch and start together with a=21, b=14 -> state goes directly to CALC, then res=7; start pulsed during CALC -> no effect on the result.
REQ-034 Assert rst mid-CALC -> all outputs 0 immediately, without waiting for a clock edge; a subsequent start with a=60, b=48 -> res=12.
REQ-035 WIDTH=16, a=65535, b=4369 -> res=4369; a=32768, b=49152 -> res=16384, latency within 33 cycles.

Source files
------------

// File: rtl/gcd_if.sv
// Handshake/operand bundle between a GCD requester and the Stein GCD engine.
interface gcd_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             start;
  logic             res_fetch;
  logic             busy;
  logic             res_rdy;
  logic [WIDTH-1:0] res;
  logic             coprime;
  logic             zero_err;

  // Requester side: drives operands and handshake, observes status/result.
  modport master (
    output a, b, start, res_fetch,
    input  busy, res_rdy, res, coprime, zero_err
  );

  // Engine side.
  modport slave (
    input  a, b, start, res_fetch,
    output busy, res_rdy, res, coprime, zero_err
  );
endinterface

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine: one reduction step per clock, IDLE/CALC/DONE
// handshake, result held in DONE until fetched. Back-to-back starts are
// accepted in the same cycle as the fetch.
module gcd_stein #(
  parameter int WIDTH = 8
) (
  input logic   clk,
  input logic   rst,
  gcd_if.slave  bus
);
  localparam int KW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0]    K_ONE = {{(KW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             coprime_q, coprime_d;
  logic             zero_err_q, zero_err_d;
  logic             busy_q, res_rdy_q;
  logic [WIDTH-1:0] x_shl_k;

  // k only counts common factors of two, so x<<k always fits in WIDTH bits.
  assign x_shl_k = x_q << k_q;

  // Next-state, datapath step and result capture.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    k_d        = k_q;
    res_d      = res_q;
    coprime_d  = coprime_q;
    zero_err_d = zero_err_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start && (state_q == IDLE || bus.res_fetch)) begin
          if (bus.a == ZERO || bus.b == ZERO) begin
            // gcd(n,0) = n: finish immediately, no CALC cycles.
            state_d    = DONE;
            res_d      = bus.a | bus.b;
            zero_err_d = (bus.a == ZERO) && (bus.b == ZERO);
            coprime_d  = ((bus.a | bus.b) == ONE);
          end else begin
            state_d = CALC;
            x_d     = bus.a;
            y_d     = bus.b;
            k_d     = {KW{1'b0}};
          end
        end else if (state_q == DONE && bus.res_fetch) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      CALC: begin
        if (x_q == y_q) begin
          state_d    = DONE;
          res_d      = x_shl_k;
          coprime_d  = (x_shl_k == ONE);
          zero_err_d = 1'b0;
        end else if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + K_ONE;
        end else if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_q > y_q) begin
          x_d = (x_q - y_q) >> 1;
        end else begin
          y_d = (y_q - x_q) >> 1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x_q        <= ZERO;
      y_q        <= ZERO;
      k_q        <= {KW{1'b0}};
      res_q      <= ZERO;
      coprime_q  <= 1'b0;
      zero_err_q <= 1'b0;
      busy_q     <= 1'b0;
      res_rdy_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      k_q        <= k_d;
      res_q      <= res_d;
      coprime_q  <= coprime_d;
      zero_err_q <= zero_err_d;
      busy_q     <= (state_d == CALC);
      res_rdy_q  <= (state_d == DONE);
    end
  end

  assign bus.busy     = busy_q;
  assign bus.res_rdy  = res_rdy_q;
  assign bus.res      = res_q;
  assign bus.coprime  = coprime_q;
  assign bus.zero_err = zero_err_q;
endmodule
